// File: rtl/bcd_to_hex_converter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_hex_converter
// Brief   : Iterative 8-digit BCD to 32-bit binary converter (reverse
//           double-dabble). Optional digit check: BCD2HEX_ERR_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_hex_converter (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [3:0]  bcd_digit_0,
   input  logic [3:0]  bcd_digit_1,
   input  logic [3:0]  bcd_digit_2,
   input  logic [3:0]  bcd_digit_3,
   input  logic [3:0]  bcd_digit_4,
   input  logic [3:0]  bcd_digit_5,
   input  logic [3:0]  bcd_digit_6,
   input  logic [3:0]  bcd_digit_7,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] hex_number,
   output logic        Error
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   localparam logic [4:0] c_LAST_ITER = 5'd31;

   state_t      r_state;
   state_t      w_state_next;
   logic [63:0] r_work;
   logic [4:0]  r_count;
   logic [31:0] r_hex;
   logic        r_done;
   logic        w_load;
   logic        w_finish;
   logic        w_reject;
   logic        w_invalid;
   logic [31:0] w_digits;
   logic [63:0] w_shifted;
   logic [63:0] w_corrected;

   assign w_digits  = {bcd_digit_7, bcd_digit_6, bcd_digit_5, bcd_digit_4,
                       bcd_digit_3, bcd_digit_2, bcd_digit_1, bcd_digit_0};
   assign w_shifted = {1'b0, r_work[63:1]};

   // After the shift, any BCD nibble that picked up a half-weight bit (>= 8) is off by 3.
   for (genvar gi = 0; gi < 8; gi++) begin : g_nib_fix
      logic [3:0] w_nib;
      assign w_nib = w_shifted[32 + 4*gi +: 4];
      assign w_corrected[32 + 4*gi +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
   end
   assign w_corrected[31:0] = w_shifted[31:0];

`ifdef BCD2HEX_ERR_CHECK_EN
   logic [7:0] w_digit_bad;
   logic       r_error;

   for (genvar gd = 0; gd < 8; gd++) begin : g_digit_chk
      assign w_digit_bad[gd] = (w_digits[4*gd +: 4] > 4'd9);
   end
   assign w_invalid = |w_digit_bad;
   assign Error     = r_error;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_error <= 1'b0;
      end else if (w_load) begin
         r_error <= 1'b0;
      end else if (w_reject) begin
         r_error <= 1'b1;
      end
   end
`else
   assign w_invalid = 1'b0;
   assign Error     = 1'b0;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_finish     = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               if (w_invalid) begin
                  w_reject = 1'b1;
               end else begin
                  w_load       = 1'b1;
                  w_state_next = S_CONV;
               end
            end
         end
         S_CONV: begin
            if (r_count == c_LAST_ITER) begin
               w_finish     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_work  <= 64'd0;
         r_count <= 5'd0;
         r_hex   <= 32'd0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_finish | w_reject;
         if (w_load) begin
            r_work  <= {w_digits, 32'd0};
            r_count <= 5'd0;
         end else if (r_state == S_CONV) begin
            r_work  <= w_corrected;
            r_count <= r_count + 5'd1;
         end
         // The final iteration's low half is already the binary result.
         if (w_finish) begin
            r_hex <= w_corrected[31:0];
         end
      end
   end

   assign Busy       = (r_state == S_CONV);
   assign Done       = r_done;
   assign hex_number = r_hex;

endmodule
`default_nettype wire
